// File: rtl/sw_debounce_sync_pkg.sv
// Shared constants for the switch conditioning path: debounce timing derived
// from the system clock, switch-index constants used by the in_port packers,
// and the per-bit qualification decision type.
package sw_debounce_sync_pkg;

    // System clock and debounce window
    localparam int CLK_FREQ_HZ        = 50_000_000;
    localparam int DEBOUNCE_MS        = 10;
    localparam int DEFAULT_STABLE_CNT = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

    // Smallest counter width that can hold DEFAULT_STABLE_CNT-1
    localparam int DEFAULT_CNT_W      = $clog2(DEFAULT_STABLE_CNT);

    // Default geometry of the DE-board switch bank
    localparam int SW_COUNT           = 11;

    // Switch positions shared with the in_port / in_port2 wiring
    localparam int SW_PORT0_LSB       = 0;   // SW0..SW4 -> in_port0
    localparam int SW_PORT1_LSB       = 5;   // SW5..SW9 -> in_port1
    localparam int SW_PORT2_BIT       = 10;  // SW10     -> in_port2 status bit

    // What a single bit does on the next clock edge
    typedef enum logic [1:0] {
        DB_AGREE  = 2'd0,   // synchronized input equals the accepted level
        DB_COUNT  = 2'd1,   // disagreeing, still qualifying
        DB_ACCEPT = 2'd2    // disagreement held long enough: take new level
    } db_action_e;

    // Classify one bit given its synchronized level, accepted level and the
    // "count has reached its terminal value" flag.
    function automatic db_action_e db_classify(input logic synced,
                                               input logic stable,
                                               input logic cnt_at_max);
        db_action_e act;
        if (synced == stable) begin
            act = DB_AGREE;
        end else if (cnt_at_max) begin
            act = DB_ACCEPT;
        end else begin
            act = DB_COUNT;
        end
        return act;
    endfunction

endpackage

// File: rtl/sw_debounce_sync_debounce_bit.sv
// Single-switch conditioner: 2-FF synchronizer, stability counter and
// registered one-cycle rise/fall pulses.
module sw_debounce_sync_debounce_bit
    import sw_debounce_sync_pkg::*;
#(
    parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter int   CNT_W      = DEFAULT_CNT_W,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    // Terminal count: the STABLE_CNT-th consecutive disagreement accepts
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    db_action_e       action;

    // Decide what this edge does for the bit
    always_comb begin
        action = db_classify(s2_q, stable_q, (cnt_q == CNT_MAX));
    end

    // Next-state for synchronizer, counter, accepted level and pulses
    always_comb begin
        s1_d     = raw_i;
        s2_d     = s1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (action)
            DB_AGREE: begin
                // Any return to the accepted level discards progress
                cnt_d = '0;
            end
            DB_COUNT: begin
                cnt_d = cnt_q + CNT_ONE;
            end
            DB_ACCEPT: begin
                stable_d = s2_q;
                cnt_d    = '0;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // State registers; reset clears progress and never produces a pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sw_debounce_sync.sv
// Conditions the raw slide switches before they reach the CPU input ports:
// one independent debouncer per switch, plus a single change flag.
module sw_debounce_sync
    import sw_debounce_sync_pkg::*;
#(
    parameter int               WIDTH      = SW_COUNT,
    parameter int               STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter int               CNT_W      = 20,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // One conditioner per switch; bits never interact
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_sync_debounce_bit #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W),
            .RESET_VAL  (RESET_VAL[i])
        ) u_bit (
            .clock    (clock),
            .resetn   (resetn),
            .raw_i    (sw_raw[i]),
            .stable_o (sw_stable[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i])
        );
    end

    // Change flag is a plain OR of the registered pulses, same cycle
    always_comb begin
        sw_changed = |(sw_rise | sw_fall);
    end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync: directed scenarios with literal expectations,
// then randomized switch activity, all checked against a behavioural model.
module tb_sw_debounce_sync;

    localparam int WIDTH      = 11;
    localparam int STABLE_CNT = 4;
    localparam int CNT_W      = 3;

    logic             clock  = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw_stable, sw_rise, sw_fall;
    logic             sw_changed;

    int vectors     = 0;
    int miscompares = 0;

    sw_debounce_sync #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W),
        .RESET_VAL  (11'h000)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Inputs reach the decision point two edges after being sampled. A bit
    // accepts its new level when the synchronized value has disagreed with the
    // accepted level on STABLE_CNT consecutive edges, measured as the distance
    // in edge numbers from the last edge on which it agreed (or accepted).
    int unsigned      edge_no = 0;
    int unsigned      since [WIDTH];
    logic [WIDTH-1:0] m_hist1 = '0, m_hist2 = '0;
    logic [WIDTH-1:0] m_stable = '0, m_rise = '0, m_fall = '0;

    always @(posedge clock or negedge resetn) begin
        logic [WIDTH-1:0] ns, nr, nf;
        if (!resetn) begin
            edge_no  = 0;
            for (int i = 0; i < WIDTH; i++) since[i] = 0;
            m_hist1  = '0;
            m_hist2  = '0;
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
        end else begin
            edge_no = edge_no + 1;
            ns = m_stable;
            nr = '0;
            nf = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_hist2[i] == m_stable[i]) begin
                    since[i] = edge_no;
                end else if (edge_no - since[i] == STABLE_CNT) begin
                    ns[i]    = m_hist2[i];
                    nr[i]    = m_hist2[i];
                    nf[i]    = ~m_hist2[i];
                    since[i] = edge_no;
                end
            end
            m_stable = ns;
            m_rise   = nr;
            m_fall   = nf;
            m_hist2  = m_hist1;
            m_hist1  = sw_raw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT against model, plus the rise/fall exclusivity rule
    always @(negedge clock) begin
        check("stable_vs_model",  32'(sw_stable),  32'(m_stable));
        check("rise_vs_model",    32'(sw_rise),    32'(m_rise));
        check("fall_vs_model",    32'(sw_fall),    32'(m_fall));
        check("changed_vs_model", 32'(sw_changed), 32'(|(m_rise | m_fall)));
        check("rise_and_fall",    32'(sw_rise & sw_fall), 32'd0);
    end

    // Advance n cycles, ending just after a falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. Reset with all switches high, then qualify all of them
        sw_raw = 11'h7FF;
        step(3);
        check("rst_stable",  32'(sw_stable),  32'h000);
        check("rst_rise",    32'(sw_rise),    32'h000);
        check("rst_changed", 32'(sw_changed), 32'h0);
        resetn = 1'b1;
        step(5);
        check("t1_pre_stable", 32'(sw_stable), 32'h000);
        step(1);
        check("t1_stable",  32'(sw_stable),  32'h7FF);
        check("t1_rise",    32'(sw_rise),    32'h7FF);
        check("t1_changed", 32'(sw_changed), 32'h1);
        step(1);
        check("t1_rise_clr",    32'(sw_rise),    32'h000);
        check("t1_changed_clr", 32'(sw_changed), 32'h0);

        // 6. Fall on bit 5
        sw_raw[5] = 1'b0;
        step(5);
        check("t6_pre_stable", 32'(sw_stable), 32'h7FF);
        step(1);
        check("t6_fall",   32'(sw_fall),   32'h020);
        check("t6_rise",   32'(sw_rise),   32'h000);
        check("t6_stable", 32'(sw_stable), 32'h7DF);
        step(1);
        check("t6_fall_clr", 32'(sw_fall), 32'h000);

        // Return everything to 0
        sw_raw = '0;
        step(8);
        check("settle0", 32'(sw_stable), 32'h000);

        // 2. Clean step on bit 3
        sw_raw[3] = 1'b1;
        step(5);
        check("t2_pre_stable", 32'(sw_stable), 32'h000);
        step(1);
        check("t2_stable", 32'(sw_stable), 32'h008);
        check("t2_rise",   32'(sw_rise),   32'h008);
        check("t2_fall",   32'(sw_fall),   32'h000);

        // 3. Bounce on bit 7, then settle high
        for (int k = 0; k < 4; k++) begin
            sw_raw[7] = (k % 2 == 0);
            step(1);
            check("t3_bounce_stable", 32'(sw_stable), 32'h008);
        end
        sw_raw[7] = 1'b1;
        step(5);
        check("t3_pre_stable", 32'(sw_stable), 32'h008);
        step(1);
        check("t3_stable", 32'(sw_stable), 32'h088);
        check("t3_rise",   32'(sw_rise),   32'h080);

        // 4. Simultaneous change on bits 0 and 10
        sw_raw = '0;
        step(8);
        check("settle1", 32'(sw_stable), 32'h000);
        sw_raw = 11'h401;
        step(5);
        check("t4_pre_changed", 32'(sw_changed), 32'h0);
        step(1);
        check("t4_rise",    32'(sw_rise),    32'h401);
        check("t4_changed", 32'(sw_changed), 32'h1);
        step(1);
        check("t4_changed_clr", 32'(sw_changed), 32'h0);

        // 5. Reset in the middle of qualifying bit 0
        sw_raw = '0;
        step(8);
        sw_raw[0] = 1'b1;
        step(3);
        resetn = 1'b0;
        step(2);
        check("t5_rst_stable", 32'(sw_stable), 32'h000);
        check("t5_rst_rise",   32'(sw_rise),   32'h000);
        resetn = 1'b1;
        step(5);
        check("t5_pre_stable", 32'(sw_stable), 32'h000);
        step(1);
        check("t5_stable", 32'(sw_stable), 32'h001);
        check("t5_rise",   32'(sw_rise),   32'h001);

        // Randomized activity: sparse level changes, bouncy bursts, rare resets
        for (int c = 0; c < 3000; c++) begin
            int unsigned mode;
            mode = $urandom_range(0, 99);
            if (mode < 20) begin
                sw_raw = sw_raw ^ WIDTH'($urandom & $urandom & $urandom);
            end else if (mode < 25) begin
                sw_raw = sw_raw ^ WIDTH'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                resetn = 1'b0;
                step($urandom_range(1, 3));
                resetn = 1'b1;
            end
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
